// File: rtl/qerv_pkg.sv
// Shared types for the qerv data-bus path.
// Access sizes, FSM states and the alignment rule.
package qerv_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Reserved size 2'b11 behaves as a word.
  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] lsb
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      (size == SIZE_B): m = 1'b0;
      (size == SIZE_H): m = lsb[0];
      default:          m = |lsb;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/qerv_dbus_if_if.sv
// Wishbone-style data bus between qerv_dbus_if and memory.
// The master drives the cycle, the slave returns data and ack.
interface qerv_dbus_if_if;
  logic [31:0] o_dbus_adr;
  logic [31:0] o_dbus_dat;
  logic [3:0]  o_dbus_sel;
  logic        o_dbus_we;
  logic        o_dbus_cyc;
  logic [31:0] i_dbus_rdt;
  logic        i_dbus_ack;

  modport master (
    output o_dbus_adr,
    output o_dbus_dat,
    output o_dbus_sel,
    output o_dbus_we,
    output o_dbus_cyc,
    input  i_dbus_rdt,
    input  i_dbus_ack
  );

  modport slave (
    input  o_dbus_adr,
    input  o_dbus_dat,
    input  o_dbus_sel,
    input  o_dbus_we,
    input  o_dbus_cyc,
    output i_dbus_rdt,
    output i_dbus_ack
  );
endinterface

// File: rtl/qerv_dbus_align.sv
// Byte-lane logic: select generation, store replication,
// load shift and sign/zero extension.
module qerv_dbus_align
  import qerv_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lsb,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] rdt,
  output logic [3:0]  sel,
  output logic [31:0] wdat,
  output logic [31:0] rdata
);

  logic [31:0] sh;

  assign sh = rdt >> {lsb, 3'b000};

  always_comb begin
    sel   = 4'b1111;
    wdat  = wdata;
    rdata = sh;
    unique case (1'b1)
      (size == SIZE_B): begin
        sel   = 4'b0001 << lsb;
        wdat  = {4{wdata[7:0]}};
        rdata = {{24{sgn & sh[7]}}, sh[7:0]};
      end
      (size == SIZE_H): begin
        sel   = 4'b0011 << {lsb[1], 1'b0};
        wdat  = {2{wdata[15:0]}};
        rdata = {{16{sgn & sh[15]}}, sh[15:0]};
      end
      default: begin
        sel   = 4'b1111;
        wdat  = wdata;
        rdata = sh;
      end
    endcase
  end

endmodule

// File: rtl/qerv_dbus_if.sv
// Data-bus stage: gathers serial store data, runs one bus
// cycle and streams the aligned load result back out.
module qerv_dbus_if
  import qerv_pkg::*;
#(
  parameter  int BITS_PER_CYCLE = 1,
  localparam int LB = $clog2(BITS_PER_CYCLE)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic                      i_start,
  input  logic                      i_we,
  input  logic [1:0]                i_size,
  input  logic                      i_signed,
  input  logic [1:0]                i_lsb,
  input  logic [31:0]               i_adr,
  input  logic [BITS_PER_CYCLE-1:0] i_rs2,
  output logic [BITS_PER_CYCLE-1:0] o_rd,
  output logic                      o_busy,
  output logic                      o_ack,
  output logic                      o_misalign,
  qerv_dbus_if_if.master            dbus
);

  localparam int BPC = 1 << LB;

  state_t      state;
  logic [31:0] data;
  logic [31:0] shifted;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic        cyc_q;
  logic [1:0]  size_q;
  logic [1:0]  lsb_q;
  logic        sgn_q;
  logic [1:0]  a_size;
  logic [1:0]  a_lsb;
  logic [3:0]  a_sel;
  logic [31:0] a_wdat;
  logic [31:0] a_rdata;
  logic        accept;

  assign shifted    = {i_rs2, data[31:BPC]};
  assign o_rd       = i_en ? data[BPC-1:0] : '0;
  assign o_misalign = misaligned(i_size, i_lsb);
  assign accept     = i_start && !o_misalign;

  // Live request fields in IDLE, latched ones once the cycle runs.
  assign a_size = (state == IDLE) ? i_size : size_q;
  assign a_lsb  = (state == IDLE) ? i_lsb  : lsb_q;

  qerv_dbus_align u_align (
    .size  (a_size),
    .lsb   (a_lsb),
    .sgn   (sgn_q),
    .wdata (data),
    .rdt   (dbus.i_dbus_rdt),
    .sel   (a_sel),
    .wdat  (a_wdat),
    .rdata (a_rdata)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      data   <= '0;
      adr_q  <= '0;
      dat_q  <= '0;
      sel_q  <= '0;
      we_q   <= 1'b0;
      cyc_q  <= 1'b0;
      size_q <= SIZE_B;
      lsb_q  <= '0;
      sgn_q  <= 1'b0;
      o_busy <= 1'b0;
      o_ack  <= 1'b0;
    end else begin
      o_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_en) data <= shifted;
          if (accept) begin
            state  <= BUS;
            cyc_q  <= 1'b1;
            o_busy <= 1'b1;
            adr_q  <= i_adr;
            we_q   <= i_we;
            sel_q  <= a_sel;
            dat_q  <= a_wdat;
            size_q <= i_size;
            lsb_q  <= i_lsb;
            sgn_q  <= i_signed;
          end
        end
        BUS: begin
          if (dbus.i_dbus_ack) begin
            state  <= DONE;
            cyc_q  <= 1'b0;
            we_q   <= 1'b0;
            o_busy <= 1'b0;
            o_ack  <= 1'b1;
            if (!we_q) data <= a_rdata;
          end
        end
        DONE: begin
          if (i_en) data <= shifted;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbus.o_dbus_adr = adr_q;
  assign dbus.o_dbus_dat = dat_q;
  assign dbus.o_dbus_sel = sel_q;
  assign dbus.o_dbus_we  = we_q;
  assign dbus.o_dbus_cyc = cyc_q;

endmodule
